// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage sitting between the program counter and decode.
//
// Issues one instruction-memory read at a time at the current PC and buffers the
// returned word with its address in a small FIFO. Decode drains the FIFO over a
// valid/ready handshake. The stage drives the PC load controls to load the reset
// vector once after reset, to step by 4 on each accepted request, and to jump on
// a redirect from execute.
//
// Parameters:
//   RESET_VECTOR         first fetch address after reset
//   FIFO_DEPTH           fetch buffer entries (power of two, >= 2)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   pc                   current program-counter value
//   pc_enable_count      PC load enable
//   pc_enable_overwrite  PC loads pc_overwrite_value instead of pc+4
//   pc_overwrite_value   PC value for an overwrite load
//   redirect_valid       single-cycle taken branch/jump from execute
//   redirect_target      new fetch address on redirect
//   imem_req_valid       memory read request
//   imem_req_addr        memory read address (equal to pc)
//   imem_req_ready       memory accepts the request this cycle
//   imem_resp_valid      memory read data valid (in order, one per request)
//   imem_resp_data       instruction word
//   dec_valid            FIFO head valid towards decode
//   dec_instr, dec_pc    FIFO head instruction and its address
//   dec_ready            decode consumes the head
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] pc,
    output logic        pc_enable_count,
    output logic        pc_enable_overwrite,
    output logic [31:0] pc_overwrite_value,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,

    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,

    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StBoot, StIdle, StWait, StDrain} state_e;

    state_e state_q, state_d;

    logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic [31:0]     inflight_q;

    logic fifo_empty;
    logic fifo_has_room;
    logic accept;
    logic push;
    logic pop;

    assign fifo_empty    = (count_q == '0);
    // Only IDLE can issue, so no slot is ever held by an outstanding request at
    // issue time; checking the live count is enough to guarantee room on return.
    assign fifo_has_room = (count_q < CntW'(FIFO_DEPTH));

    assign accept = imem_req_valid & imem_req_ready;
    // A redirect kills a response that lands in the same cycle.
    assign push   = (state_q == StWait) & imem_resp_valid & ~redirect_valid;
    assign pop    = dec_valid & dec_ready;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: state_d = StIdle;
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // With a response the word is either pushed or dropped; either way
                // nothing remains outstanding. Without one, a redirect must discard it.
                if (imem_resp_valid) begin
                    state_d = StIdle;
                end else if (redirect_valid) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (imem_resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        imem_req_valid      = (state_q == StIdle) & ~redirect_valid & fifo_has_room;
        imem_req_addr       = pc;
        // rst_n gating keeps the PC controls quiet while reset is held.
        pc_enable_count     = rst_n & (accept | redirect_valid | (state_q == StBoot));
        pc_enable_overwrite = rst_n & (redirect_valid | (state_q == StBoot));
        pc_overwrite_value  = redirect_valid ? redirect_target : RESET_VECTOR;
        dec_valid           = rst_n & ~fifo_empty & ~redirect_valid;
        dec_instr           = fifo_instr_q[rd_ptr_q];
        dec_pc              = fifo_pc_q[rd_ptr_q];
    end

    // ---------------------------------------------------------------- in-flight address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else if (accept) begin
            inflight_q <= pc;
        end
    end

    // ---------------------------------------------------------------- fetch buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_pc_q    <= '{default: '0};
            fifo_instr_q <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else if (redirect_valid) begin
            // Flush: entries become unreachable, storage contents left as is.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= inflight_q;
                fifo_instr_q[wr_ptr_q] <= imem_resp_data;
                wr_ptr_q               <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a PC register and a fixed-latency
// memory around the DUT, a queue-based reference model checked every cycle, and
// directed phases with hand-computed expectations.
module tb_instruction_fetch;

    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_enable_count;
    logic        pc_enable_overwrite;
    logic [31:0] pc_overwrite_value;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch #(
        .RESET_VECTOR (RV),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc                  (pc),
        .pc_enable_count     (pc_enable_count),
        .pc_enable_overwrite (pc_enable_overwrite),
        .pc_overwrite_value  (pc_overwrite_value),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .imem_req_valid      (imem_req_valid),
        .imem_req_addr       (imem_req_addr),
        .imem_req_ready      (imem_req_ready),
        .imem_resp_valid     (imem_resp_valid),
        .imem_resp_data      (imem_resp_data),
        .dec_valid           (dec_valid),
        .dec_instr           (dec_instr),
        .dec_pc              (dec_pc),
        .dec_ready           (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h0000_00A0 + ((a - 32'h0000_0100) >> 2);
    endfunction

    // ---------------------------------------------------------------- PC register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (pc_enable_count) begin
            pc <= pc_enable_overwrite ? pc_overwrite_value : pc + 32'd4;
        end
    end

    // ---------------------------------------------------------------- memory, latency lat
    int          lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_busy <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= '0;
        end else if (imem_req_valid && imem_req_ready) begin
            mem_busy <= 1'b1;
            mem_cnt  <= lat - 1;
            mem_addr <= imem_req_addr;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end
    end

    assign imem_resp_valid = mem_busy && (mem_cnt == 0);
    assign imem_resp_data  = word_of(mem_addr);

    // ---------------------------------------------------------------- cycle index since reset
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------------------------------------------------------- reference model + compare
    logic [63:0] m_q [$];
    bit          m_boot;
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_inflight;
    int          acc [$];
    logic [63:0] got [$];

    always @(negedge clk) begin
        bit          exp_req;
        bit          exp_cnt;
        bit          exp_dv;
        logic [63:0] head;
        if (!rst_n) begin
            check_bit("rst_en_count", pc_enable_count, 1'b0);
            check_bit("rst_en_ow", pc_enable_overwrite, 1'b0);
            check_bit("rst_req_valid", imem_req_valid, 1'b0);
            check("rst_req_addr", imem_req_addr, 32'h0);
            check_bit("rst_dec_valid", dec_valid, 1'b0);
            check("rst_dec_pc", dec_pc, 32'h0);
            check("rst_dec_instr", dec_instr, 32'h0);
            m_q.delete();
            m_boot = 1'b1;
            m_out  = 1'b0;
            m_drop = 1'b0;
            m_inflight = '0;
        end else begin
            exp_req = !m_boot && !m_out && !m_drop && !redirect_valid && (m_q.size() < DEPTH);
            exp_cnt = (exp_req && imem_req_ready) || redirect_valid || m_boot;
            exp_dv  = (m_q.size() > 0) && !redirect_valid;
            check_bit("req_valid", imem_req_valid, exp_req);
            check("req_addr", imem_req_addr, pc);
            check_bit("en_count", pc_enable_count, exp_cnt);
            check_bit("en_ow", pc_enable_overwrite, redirect_valid || m_boot);
            check("ow_value", pc_overwrite_value, redirect_valid ? redirect_target : RV);
            check_bit("dec_valid", dec_valid, exp_dv);
            if (exp_dv) begin
                head = m_q[0];
                check("dec_pc", dec_pc, head[63:32]);
                check("dec_instr", dec_instr, head[31:0]);
            end
            if (imem_req_valid && imem_req_ready) acc.push_back(cyc);
            if (dec_valid && dec_ready) got.push_back({dec_pc, dec_instr});

            // Advance the model to what the next edge must produce.
            m_boot = 1'b0;
            if (redirect_valid) begin
                m_q.delete();
                if (m_out) begin
                    m_out  = 1'b0;
                    m_drop = !imem_resp_valid;
                end else if (m_drop && imem_resp_valid) begin
                    m_drop = 1'b0;
                end
            end else begin
                if (exp_dv && dec_ready) void'(m_q.pop_front());
                if (m_out && imem_resp_valid) begin
                    m_q.push_back({m_inflight, imem_resp_data});
                    m_out = 1'b0;
                end else if (m_drop && imem_resp_valid) begin
                    m_drop = 1'b0;
                end
                if (exp_req && imem_req_ready) begin
                    m_out      = 1'b1;
                    m_inflight = pc;
                end
            end
        end
    end

    // ---------------------------------------------------------------- directed helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Resets, checks the BOOT cycle, and returns in cycle 1.
    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        acc.delete();
        #1;
        check_bit("boot_en_count", pc_enable_count, 1'b1);
        check_bit("boot_en_ow", pc_enable_overwrite, 1'b1);
        check("boot_ow_value", pc_overwrite_value, RV);
        check_bit("boot_req_valid", imem_req_valid, 1'b0);
        step();
        check("boot_pc", pc, RV);
        check_bit("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, RV);
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("deliveries", 32'(got.size() >= n), 32'd1);
    endtask

    task automatic check_pair(input string name, input int idx, input logic [31:0] p,
                              input logic [31:0] w);
        logic [63:0] g;
        g = (idx < got.size()) ? got[idx] : 64'hx;
        check({name, "_pc"}, g[63:32], p);
        check({name, "_instr"}, g[31:0], w);
    endtask

    // ---------------------------------------------------------------- directed phases
    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_req_ready  = 1'b1;
        dec_ready       = 1'b1;
        lat             = 1;

        // Straight-line fetch, 1-cycle memory.
        do_reset();
        wait_got(3, 30);
        check_pair("sl0", 0, 32'h100, 32'hA0);
        check_pair("sl1", 1, 32'h104, 32'hA1);
        check_pair("sl2", 2, 32'h108, 32'hA2);
        check("sl_first_accept", 32'(acc[0]), 32'd1);
        check("sl_accept_gap0", 32'(acc[1] - acc[0]), 32'd2);
        check("sl_accept_gap1", 32'(acc[2] - acc[1]), 32'd2);

        // Backpressure: FIFO fills, head holds, then drains with no loss.
        dec_ready = 1'b0;
        do_reset();
        repeat (12) begin
            step();
            if (cyc >= 3) begin
                check("bp_head_pc", dec_pc, 32'h100);
                check("bp_head_instr", dec_instr, 32'hA0);
            end
        end
        check("bp_accepts", 32'(acc.size()), 32'(DEPTH));
        check_bit("bp_req_valid", imem_req_valid, 1'b0);
        dec_ready = 1'b1;
        wait_got(4, 30);
        check_pair("bp0", 0, 32'h100, 32'hA0);
        check_pair("bp1", 1, 32'h104, 32'hA1);
        check_pair("bp2", 2, 32'h108, 32'hA2);
        check_pair("bp3", 3, 32'h10C, 32'hA3);

        // Memory not ready for 3 cycles.
        imem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check_bit("rl_req_valid", imem_req_valid, 1'b1);
            check("rl_req_addr", imem_req_addr, 32'h100);
            check_bit("rl_en_count", pc_enable_count, 1'b0);
            step();
        end
        check("rl_pc_held", pc, 32'h100);
        imem_req_ready = 1'b1;
        #1;
        check_bit("rl_accept_count", pc_enable_count, 1'b1);
        step();
        check("rl_accepts", 32'(acc.size()), 32'd1);
        check("rl_pc_adv", pc, 32'h104);
        check_bit("rl_wait_req", imem_req_valid, 1'b0);

        // Redirect in WAIT with a buffered entry; response lands 2 cycles later.
        dec_ready = 1'b0;
        lat       = 1;
        do_reset();                        // cycle 1: accept 0x100
        step();                            // cycle 2: response pushed
        step();                            // cycle 3: accept 0x104 with latency 3
        lat = 3;
        #1;
        check_bit("rw_buffered", dec_valid, 1'b1);
        step();                            // cycle 4: redirect
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        dec_ready       = 1'b1;
        #1;
        check_bit("rw_en_count", pc_enable_count, 1'b1);
        check_bit("rw_en_ow", pc_enable_overwrite, 1'b1);
        check("rw_ow_value", pc_overwrite_value, 32'h200);
        check_bit("rw_dec_valid", dec_valid, 1'b0);
        step();                            // cycle 5: draining
        redirect_valid = 1'b0;
        #1;
        check("rw_pc", pc, 32'h200);
        check_bit("rw_drain_req", imem_req_valid, 1'b0);
        check_bit("rw_flushed", dec_valid, 1'b0);
        step();                            // cycle 6: late response dropped
        check_bit("rw_drop_req", imem_req_valid, 1'b0);
        step();                            // cycle 7: fetch at target
        check_bit("rw_target_req", imem_req_valid, 1'b1);
        check("rw_target_addr", imem_req_addr, 32'h200);
        wait_got(1, 30);
        check_pair("rw0", 0, 32'h200, 32'hE0);

        // Redirect in the same cycle as the response.
        lat = 2;
        do_reset();                        // cycle 1: accept 0x100
        step();                            // cycle 2: waiting
        step();                            // cycle 3: response + redirect
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1;
        check_bit("rs_req_valid", imem_req_valid, 1'b0);
        check_bit("rs_dec_valid", dec_valid, 1'b0);
        check_bit("rs_en_count", pc_enable_count, 1'b1);
        step();                            // cycle 4: request to target
        redirect_valid = 1'b0;
        #1;
        check("rs_pc", pc, 32'h200);
        check_bit("rs_target_req", imem_req_valid, 1'b1);
        check("rs_target_addr", imem_req_addr, 32'h200);
        wait_got(1, 30);
        check_pair("rs0", 0, 32'h200, 32'hE0);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
